// File: rtl/encrypt_pkg.sv
// Shared constants and types for the shift-cipher pipe stages.
package encrypt_pkg;

    localparam int unsigned ALPHA_LEN        = 26;
    localparam logic [7:0]  ASCII_UPPER_BASE = 8'd65;
    localparam logic [7:0]  ASCII_LOW_BASE   = 8'd97;
    localparam logic [7:0]  ASCII_ERR        = 8'h3F;

    typedef logic [25:0] alpha_onehot_t;
    typedef logic [4:0]  alpha_idx_t;

endpackage

// File: rtl/encrypt_pipe_shift_rot_if.sv
// Data bus between the compare stage and the shift/rotate stage.
interface encrypt_pipe_shift_rot_if;

    logic        en;
    logic        is_alpha_upper_case;
    logic        is_alpha_low_case;
    logic [31:0] extended_shift_data;
    logic        en_out;
    logic [7:0]  dout;
    logic        onehot_err_out;

    modport master (
        output en, is_alpha_upper_case, is_alpha_low_case, extended_shift_data,
        input  en_out, dout, onehot_err_out
    );

    modport slave (
        input  en, is_alpha_upper_case, is_alpha_low_case, extended_shift_data,
        output en_out, dout, onehot_err_out
    );

endinterface

// File: rtl/onehot26_encode.sv
// Combinational 26-bit one-hot to index encoder; valid_out means exactly one bit set.
module onehot26_encode
    import encrypt_pkg::*;
(
    input  alpha_onehot_t oh_in,
    output alpha_idx_t    idx_out,
    output logic          valid_out
);

    always_comb begin
        idx_out = '0;
        for (int unsigned i = 0; i < ALPHA_LEN; i++) begin
            if (oh_in[i]) begin
                idx_out = idx_out | alpha_idx_t'(i);
            end
        end
        valid_out = (oh_in != '0) && ((oh_in & (oh_in - 26'd1)) == '0);
    end

endmodule

// File: rtl/encrypt_pipe_shift_rot.sv
// Shift-cipher rotor stage: rotates the one-hot alphabet position and re-encodes to ASCII.
// Optional ENCRYPT_ROT_STATS_EN adds a saturating alpha_count_out.
module encrypt_pipe_shift_rot #(
    parameter int unsigned ALPHA_LEN = 26,
    parameter int unsigned OFS_W     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    encrypt_pipe_shift_rot_if.slave  bus,
    input  logic [2:0]               shift_amt,
    input  logic [2:0]               rot_freq,
    input  logic                     cfg_load,
    input  logic                     decrypt,
    output logic [OFS_W-1:0]         rot_offset_out
`ifdef ENCRYPT_ROT_STATS_EN
    ,
    output logic [15:0]              alpha_count_out
`endif
);

    import encrypt_pkg::ASCII_UPPER_BASE;
    import encrypt_pkg::ASCII_LOW_BASE;
    import encrypt_pkg::ASCII_ERR;
    import encrypt_pkg::alpha_onehot_t;
    import encrypt_pkg::alpha_idx_t;

    logic             en_out_q, en_out_d;
    logic [7:0]       dout_q, dout_d;
    logic             err_q, err_d;
    logic [OFS_W-1:0] offset_q, offset_d;
    logic [2:0]       cnt_q, cnt_d;

    alpha_onehot_t          in_oh, rot_oh;
    logic [2*ALPHA_LEN-1:0] dbl_fwd, dbl_bwd;
    alpha_idx_t             rot_idx;
    logic                   rot_valid;
    logic                   is_alpha;
    logic [7:0]             ascii_base;
    logic [OFS_W:0]         ofs_sum;
    logic [OFS_W:0]         ofs_wrap;
    logic                   unused_data_hi;

    assign unused_data_hi = ^bus.extended_shift_data[31:ALPHA_LEN];

    // Rotation within ALPHA_LEN bits via a doubled vector: the wrapped bits land in the kept window.
    always_comb begin
        in_oh   = bus.extended_shift_data[ALPHA_LEN-1:0];
        dbl_fwd = {in_oh, in_oh} << offset_q;
        dbl_bwd = {in_oh, in_oh} >> offset_q;
        rot_oh  = decrypt ? dbl_bwd[ALPHA_LEN-1:0] : dbl_fwd[2*ALPHA_LEN-1:ALPHA_LEN];
    end

    onehot26_encode u_encode (
        .oh_in     (rot_oh),
        .idx_out   (rot_idx),
        .valid_out (rot_valid)
    );

    always_comb begin
        is_alpha   = bus.en && (bus.is_alpha_upper_case || bus.is_alpha_low_case);
        ascii_base = bus.is_alpha_upper_case ? ASCII_UPPER_BASE : ASCII_LOW_BASE;

        en_out_d = bus.en;
        dout_d   = dout_q;
        err_d    = err_q;
        if (bus.en) begin
            err_d = 1'b0;
            if (!is_alpha) begin
                dout_d = bus.extended_shift_data[7:0];
            end else if (!rot_valid) begin
                dout_d = ASCII_ERR;
                err_d  = 1'b1;
            end else begin
                dout_d = ascii_base + {3'b000, rot_idx};
            end
        end
    end

    // Offset plus step never exceeds 2*ALPHA_LEN, so one conditional subtract is the modulo.
    always_comb begin
        ofs_sum  = {1'b0, offset_q} + {{(OFS_W-2){1'b0}}, shift_amt};
        ofs_wrap = (ofs_sum >= (OFS_W+1)'(ALPHA_LEN)) ? ofs_sum - (OFS_W+1)'(ALPHA_LEN) : ofs_sum;

        offset_d = offset_q;
        cnt_d    = cnt_q;
        if (cfg_load) begin
            offset_d = OFS_W'(shift_amt);
            cnt_d    = '0;
        end else if (is_alpha) begin
            if (rot_freq == 3'd0) begin
                cnt_d = '0;
            end else if (cnt_q == rot_freq - 3'd1) begin
                cnt_d    = '0;
                offset_d = ofs_wrap[OFS_W-1:0];
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out_q <= 1'b0;
            dout_q   <= '0;
            err_q    <= 1'b0;
            offset_q <= '0;
            cnt_q    <= '0;
        end else begin
            en_out_q <= en_out_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.en_out         = en_out_q;
    assign bus.dout           = dout_q;
    assign bus.onehot_err_out = err_q;
    assign rot_offset_out     = offset_q;

`ifdef ENCRYPT_ROT_STATS_EN
    logic [15:0] alpha_cnt_q, alpha_cnt_d;

    always_comb begin
        alpha_cnt_d = alpha_cnt_q;
        if (cfg_load) begin
            alpha_cnt_d = '0;
        end else if (is_alpha && (alpha_cnt_q != '1)) begin
            alpha_cnt_d = alpha_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alpha_cnt_q <= '0;
        end else begin
            alpha_cnt_q <= alpha_cnt_d;
        end
    end

    assign alpha_count_out = alpha_cnt_q;
`endif

endmodule

// File: tb/tb_encrypt_pipe_shift_rot.sv
// Directed, table-driven bench for encrypt_pipe_shift_rot (stats checks under ENCRYPT_ROT_STATS_EN).
module tb_encrypt_pipe_shift_rot;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] shift_amt;
    logic [2:0] rot_freq;
    logic       cfg_load;
    logic       decrypt;
    logic [4:0] rot_offset_out;
`ifdef ENCRYPT_ROT_STATS_EN
    logic [15:0] alpha_count_out;
`endif

    int errors = 0;
    int checks = 0;

    encrypt_pipe_shift_rot_if bus ();

    encrypt_pipe_shift_rot #(.ALPHA_LEN(26), .OFS_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .shift_amt      (shift_amt),
        .rot_freq       (rot_freq),
        .cfg_load       (cfg_load),
        .decrypt        (decrypt),
        .rot_offset_out (rot_offset_out)
`ifdef ENCRYPT_ROT_STATS_EN
        ,
        .alpha_count_out(alpha_count_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cl;
        logic [2:0]  sa;
        logic [2:0]  rf;
        logic        dec;
        logic        en;
        logic        up;
        logic        lo;
        logic [31:0] data;
        logic        e_en;
        logic [7:0]  e_dout;
        logic        e_err;
        logic [4:0]  e_off;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cl, input logic [2:0] sa, input logic [2:0] rf, input logic dec,
                         input logic en, input logic up, input logic lo, input logic [31:0] data);
        cfg_load                = cl;
        shift_amt               = sa;
        rot_freq                = rf;
        decrypt                 = dec;
        bus.en                  = en;
        bus.is_alpha_upper_case = up;
        bus.is_alpha_low_case   = lo;
        bus.extended_shift_data = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           cl    sa    rf    dec   en    up    lo    data            e_en  e_dout e_err e_off
        vecs[0]  = '{1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 5'd3};
        vecs[1]  = '{1'b0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h44, 1'b0, 5'd3};
        vecs[2]  = '{1'b0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h44, 1'b0, 5'd3};
        vecs[3]  = '{1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h44, 1'b0, 5'd1};
        vecs[4]  = '{1'b0, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0200_0000, 1'b1, 8'h61, 1'b0, 5'd1};
        vecs[5]  = '{1'b0, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1,         1'b1, 8'h7A, 1'b0, 5'd1};
        vecs[6]  = '{1'b1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h7A, 1'b0, 5'd3};
        vecs[7]  = '{1'b0, 3'd3, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h44, 1'b0, 5'd3};
        vecs[8]  = '{1'b0, 3'd3, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h35,        1'b1, 8'h35, 1'b0, 5'd3};
        vecs[9]  = '{1'b0, 3'd3, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h44, 1'b0, 5'd6};
        vecs[10] = '{1'b0, 3'd3, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h47, 1'b0, 5'd6};
        vecs[11] = '{1'b0, 3'd3, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h47, 1'b0, 5'd9};
        vecs[12] = '{1'b0, 3'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h4A, 1'b0, 5'd12};
        vecs[13] = '{1'b0, 3'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h4D, 1'b0, 5'd15};
        vecs[14] = '{1'b0, 3'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h50, 1'b0, 5'd18};
        vecs[15] = '{1'b0, 3'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h53, 1'b0, 5'd21};
        vecs[16] = '{1'b0, 3'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h56, 1'b0, 5'd24};
        vecs[17] = '{1'b0, 3'd3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h59, 1'b0, 5'd1};
        vecs[18] = '{1'b1, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h42, 1'b0, 5'd5};
        vecs[19] = '{1'b0, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h46, 1'b0, 5'd5};
        vecs[20] = '{1'b0, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h46, 1'b0, 5'd10};
        vecs[21] = '{1'b0, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3,         1'b1, 8'h3F, 1'b1, 5'd10};
        vecs[22] = '{1'b0, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1,         1'b1, 8'h4B, 1'b0, 5'd15};
        vecs[23] = '{1'b0, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 8'h4B, 1'b0, 5'd15};
        vecs[24] = '{1'b0, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4,         1'b1, 8'h52, 1'b0, 5'd15};
        vecs[25] = '{1'b0, 3'd5, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1,         1'b1, 8'h6C, 1'b0, 5'd20};
        vecs[26] = '{1'b0, 3'd5, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b1, 8'h3F, 1'b1, 5'd20};

        rst = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("reset en_out", {31'd0, bus.en_out}, 32'd0);
        check("reset dout", {24'd0, bus.dout}, 32'd0);
        check("reset err", {31'd0, bus.onehot_err_out}, 32'd0);
        check("reset offset", {27'd0, rot_offset_out}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].cl, vecs[i].sa, vecs[i].rf, vecs[i].dec,
                  vecs[i].en, vecs[i].up, vecs[i].lo, vecs[i].data);
            check($sformatf("v%0d en_out", i), {31'd0, bus.en_out}, {31'd0, vecs[i].e_en});
            check($sformatf("v%0d dout", i), {24'd0, bus.dout}, {24'd0, vecs[i].e_dout});
            check($sformatf("v%0d err", i), {31'd0, bus.onehot_err_out}, {31'd0, vecs[i].e_err});
            check($sformatf("v%0d offset", i), {27'd0, rot_offset_out}, {27'd0, vecs[i].e_off});
        end

`ifdef ENCRYPT_ROT_STATS_EN
        check("stats after table", {16'd0, alpha_count_out}, 32'd7);
`endif

        // Reset while a character is in flight discards it.
        rst = 1'b1;
        drive(1'b0, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1);
        check("midrst en_out", {31'd0, bus.en_out}, 32'd0);
        check("midrst dout", {24'd0, bus.dout}, 32'd0);
        check("midrst err", {31'd0, bus.onehot_err_out}, 32'd0);
        check("midrst offset", {27'd0, rot_offset_out}, 32'd0);
`ifdef ENCRYPT_ROT_STATS_EN
        check("midrst stats", {16'd0, alpha_count_out}, 32'd0);
`endif
        rst = 1'b0;
        drive(1'b0, 3'd5, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1);
        check("postrst dout", {24'd0, bus.dout}, 32'h41);
        check("postrst offset", {27'd0, rot_offset_out}, 32'd0);

`ifdef ENCRYPT_ROT_STATS_EN
        drive(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("stats cfg clear", {16'd0, alpha_count_out}, 32'd0);
        for (int n = 0; n < 70000; n++) begin
            drive(1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1);
        end
        check("stats saturate", {16'd0, alpha_count_out}, 32'h0000_FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encrypt_pipe_shift_rot.md
Name: encrypt_pipe_shift_rot

Overview:
- Second pipe stage of the shift-cipher path, directly downstream of the data-compare stage.
- Consumes the compare stage's registered outputs: enable, upper/lower-case flags, and the 32-bit extended shift data (one-hot alphabet position in [25:0], or the raw byte in [7:0]).
- Rotates the one-hot by a rotor offset that advances every rot_freq alphabetic characters, then re-encodes the result to ASCII.
- Produces one registered output byte per enabled input, with 1-cycle latency.

Parameters:
ALPHA_LEN, 26, alphabet size; rotation modulus and one-hot width.
OFS_W, 5, width of the rotor offset register.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  input valid, from the compare stage en_out.
is_alpha_upper_case  in  1  input is 'A'..'Z'.
is_alpha_low_case  in  1  input is 'a'..'z'.
extended_shift_data  in  32  one-hot position [25:0], or raw byte in [7:0].
shift_amt  in  3  rotor step, and the offset loaded on cfg_load.
rot_freq  in  3  alphabetic characters per rotor step; 0 means a static rotor.
cfg_load  in  1  pulse: offset <= shift_amt, char counter <= 0.
decrypt  in  1  0 = rotate forward, 1 = rotate backward.
en_out  out  1  output valid.
dout  out  8  encrypted/decrypted byte.
onehot_err_out  out  1  1-cycle pulse: alpha flag set but [25:0] not exactly one-hot.
rot_offset_out  out  5  current rotor offset (0..25).

Behaviour:
- Reset (rst=1 at a clock edge):
  - en_out, dout, onehot_err_out, rot_offset_out, internal offset and char counter all go to 0.
  - Reset mid-stream discards the in-flight character.
- Latency: every registered output reflects the inputs sampled at the previous edge. en_out <= en.
- Alpha character (en=1, either case flag set, [25:0] exactly one-hot):
  - Encrypt: rot = [25:0] rotated left by offset within 26 bits.
  - Decrypt: rot = [25:0] rotated right by offset within 26 bits.
  - idx = one-hot encode of rot (0..25).
  - dout = 65+idx for upper case, 97+idx for lower case.
- Non-alpha character (en=1, both flags 0): dout = extended_shift_data[7:0]; char counter unchanged.
- Both case flags set: treated as upper case.
- Alpha flag set but [25:0] zero or multi-hot:
  - dout = 8'h3F ('?'), onehot_err_out = 1.
  - Counter still advances.
- en=0: dout and onehot_err_out hold their last values; en_out = 0; no counter activity.
- Rotor, for each alpha character with rot_freq != 0:
  - If cnt == rot_freq-1: cnt <= 0 and offset <= (offset+shift_amt) mod 26. The sum is at most 32, so mod is a single conditional subtract of 26.
  - Otherwise: cnt <= cnt+1.
- The character that triggers a step uses the pre-step offset.
- rot_freq = 0: offset static, counter held at 0.
- cfg_load has priority over a rotor step in the same cycle:
  - Offset and counter are reloaded.
  - A character presented in that cycle is processed with the pre-load offset.
- shift_amt >= 26 cannot occur (3-bit input).
- rot_offset_out mirrors the offset register.

Optional Feature:
- Macro: ENCRYPT_ROT_STATS_EN.
- When defined:
  - Adds output alpha_count_out [15:0]: number of alpha characters processed, saturating at 16'hFFFF.
  - Cleared by rst and by cfg_load.
  - Increments in the same cycle as the counter decision.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package encrypt_pkg holds:
  - Constants: ALPHA_LEN=26, ASCII_UPPER_BASE=8'd65, ASCII_LOW_BASE=8'd97, ASCII_ERR=8'h3F.
  - Typedefs: alpha_onehot_t (logic [25:0]) and alpha_idx_t (logic [4:0]).
- Sub-module onehot26_encode (combinational): 26-bit one-hot in; 5-bit index and valid flag out, where valid means exactly one bit set.
- Rotation, rotor counter and output registers stay in encrypt_pipe_shift_rot.

Test Plan:
- Pulse cfg_load with shift_amt=3, rot_freq=0; send 'A' (bit0) -> next cycle en_out=1, dout=8'h44 ('D'); rot_offset_out stays 3.
- Offset 1 (shift_amt=1), encrypt, send 'z' (bit25, low flag) -> dout=8'h61 ('a'). Same setup with decrypt=1, send 'a' -> dout=8'h7A ('z').
- shift_amt=3, rot_freq=2, cfg_load; send 'A' x4 -> dout D,D,G,G; rot_offset_out goes 3,3,6,6,9. Insert '5' (8'h35, no flags) mid-stream -> dout=8'h35, rotor step count unchanged.
- Wrap: drive the offset to 24, step of 3 -> offset 1. Same cycle: cfg_load plus an alpha character -> character uses the old offset, then offset = shift_amt and counter = 0.
- Upper flag set with [25:0]=26'h3 -> dout=8'h3F, onehot_err_out pulses for exactly one cycle.
- Assert rst mid-stream with en=1 -> next cycle all outputs 0 and offset 0. With ENCRYPT_ROT_STATS_EN: 70000 alpha characters -> alpha_count_out=16'hFFFF.
